// File: rtl/rm25c256_rd_ctrl_if.sv
// Host-side request/response bundle for the RM25C256 read controller.
// The host (master) issues start/addr/len and observes busy/done and the
// received byte stream; the controller is the slave.
interface rm25c256_rd_ctrl_if #(
  parameter int LEN_W = 8
) ();
  logic             start;
  logic [15:0]      addr;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic [7:0]       rd_data;
  logic             rd_valid;

  modport master (
    output start, addr, len,
    input  busy, done, rd_data, rd_valid
  );

  modport slave (
    input  start, addr, len,
    output busy, done, rd_data, rd_valid
  );
endinterface

// File: rtl/rm25c256_rd_ctrl.sv
// RM25C256 SPI EEPROM sequential-read controller (SPI mode 0).
// Sends READ (0x03) plus a 16-bit address, then clocks in len bytes,
// handing each one out with a single-cycle rd_valid strobe.
// The sequence is SETUP (H cycles) -> SHIFT -> HOLD (H cycles) ->
// DESEL (CLK_SCK_SCAL cycles) -> one done cycle -> IDLE.
module rm25c256_rd_ctrl #(
  parameter int CLK_SCK_SCAL = 40,
  parameter int LEN_W        = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  rm25c256_rd_ctrl_if.slave   host,
  output logic                csb,
  output logic                sck,
  output logic                mosi,
  input  logic                miso
);

  localparam int     H        = CLK_SCK_SCAL / 2;
  localparam int     PH_W     = $clog2(CLK_SCK_SCAL);
  localparam longint MAX_BITS = 24 + 8 * ((longint'(1) << LEN_W) - 1);
  localparam int     BC_W     = $clog2(MAX_BITS);

  localparam logic [PH_W-1:0] H_M1 = PH_W'(H - 1);
  localparam logic [PH_W-1:0] P_M1 = PH_W'(CLK_SCK_SCAL - 1);
  localparam logic [7:0]      CMD_READ = 8'h03;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DESEL = 3'd4;

  logic [2:0]      state;
  logic [PH_W-1:0] ph;        // position inside the current SCK period / phase
  logic [BC_W-1:0] bitc;      // bit index within the whole frame (cmd+addr+data)
  logic [BC_W-1:0] last_m1;   // index of the final frame bit, 23 + 8*len
  logic [23:0]     tx_sr;     // command+address, MSB first, zero-filled on shift
  logic [6:0]      rx_sr;     // first seven bits of the byte being received
  logic            busy_q;
  logic            done_q;
  logic [7:0]      rd_data_q;
  logic            rd_valid_q;
  logic            sample_en;

  assign host.busy     = busy_q;
  assign host.done     = done_q;
  assign host.rd_data  = rd_data_q;
  assign host.rd_valid = rd_valid_q;

  // miso is taken on the edge that raises sck, only once the data bits begin
  assign sample_en = (state == S_SHIFT) && (ph == H_M1) && (bitc >= BC_W'(24));

  // Frame sequencer: state, SCK phase/bit counting and all SPI pin drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      ph      <= '0;
      bitc    <= '0;
      last_m1 <= '0;
      tx_sr   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      csb     <= 1'b1;
      sck     <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (host.start && (host.len != '0)) begin
            state   <= S_SETUP;
            ph      <= '0;
            bitc    <= '0;
            tx_sr   <= {CMD_READ, host.addr};
            last_m1 <= BC_W'(23) + (BC_W'(host.len) << 3);
            busy_q  <= 1'b1;
            csb     <= 1'b0;
            mosi    <= CMD_READ[7];
          end
        end

        S_SETUP: begin
          if (ph == H_M1) begin
            state <= S_SHIFT;
            ph    <= '0;
          end else begin
            ph <= ph + PH_W'(1);
          end
        end

        S_SHIFT: begin
          if (ph == H_M1) begin
            sck <= 1'b1;
            ph  <= ph + PH_W'(1);
          end else if (ph == P_M1) begin
            // falling edge: the only place mosi is allowed to move
            sck <= 1'b0;
            ph  <= '0;
            if (bitc == last_m1) begin
              state <= S_HOLD;
              mosi  <= 1'b0;
            end else begin
              bitc  <= bitc + BC_W'(1);
              tx_sr <= {tx_sr[22:0], 1'b0};
              mosi  <= tx_sr[22];
            end
          end else begin
            ph <= ph + PH_W'(1);
          end
        end

        S_HOLD: begin
          if (ph == H_M1) begin
            state <= S_DESEL;
            csb   <= 1'b1;
            ph    <= '0;
          end else begin
            ph <= ph + PH_W'(1);
          end
        end

        S_DESEL: begin
          if (done_q) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ph     <= '0;
            bitc   <= '0;
          end else if (ph == P_M1) begin
            done_q <= 1'b1;
          end else begin
            ph <= ph + PH_W'(1);
          end
        end

        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          csb    <= 1'b1;
          sck    <= 1'b0;
          mosi   <= 1'b0;
        end
      endcase
    end
  end

  // Receive path: assemble bytes MSB first, publish each with a one-cycle strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_sr      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      if (sample_en) begin
        rx_sr <= {rx_sr[5:0], miso};
        // data bits start at index 24, so the low three bits mark the byte's last bit
        if (bitc[2:0] == 3'b111) begin
          rd_data_q  <= {rx_sr, miso};
          rd_valid_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rm25c256_rd_ctrl.sv
// Bench for rm25c256_rd_ctrl with CLK_SCK_SCAL=4 (H=2): a table of read
// transactions plus hand sequences for len=0, start during SHIFT, reset
// abort and start coincident with done. A behavioural EEPROM drives miso.
module tb_rm25c256_rd_ctrl;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic csb, sck, mosi;
  logic miso    = 1'b0;

  rm25c256_rd_ctrl_if #(.LEN_W(8)) hif ();

  rm25c256_rd_ctrl #(.CLK_SCK_SCAL(4), .LEN_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .host    (hif.slave),
    .csb     (csb),
    .sck     (sck),
    .mosi    (mosi),
    .miso    (miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // stimulus-side state (written only by the test process)
  logic [7:0] mb [4];
  int         len_exp = 0;
  int         n_checks = 0;
  int         n_fail   = 0;

  // monitor-side state (written only by the monitor process)
  logic        sck_d = 1'b0, csb_d = 1'b1, mosi_d = 1'b0, busy_d = 1'b0, rst_d = 1'b0;
  int          rise_cnt = 0, last_rise = -1;
  logic [23:0] mosi_cap = '0;
  int          mon_err = 0, nbusy = 0, ncsb = 0, ndone = 0, nval = 0;
  int          busy_rise = 0, done_cyc = 0;
  logic [7:0]  val_data [16];
  int          val_cyc  [16];

  // EEPROM model and protocol monitor, evaluated away from the active edge
  always @(negedge clk) begin
    int k;
    if (reset_n && rst_d) begin
      if (sck && (mosi != mosi_d)) mon_err++;
      if ((csb != csb_d) && (sck || sck_d)) mon_err++;
      if (!hif.busy && (!csb || sck || mosi)) mon_err++;
      if (hif.done && !hif.busy) mon_err++;
    end
    if (!csb && csb_d) begin
      rise_cnt  = 0;
      last_rise = -1;
      mosi_cap  = '0;
    end
    if (sck && !sck_d && !csb) begin
      if (rise_cnt < 24) mosi_cap = {mosi_cap[22:0], mosi};
      if ((last_rise >= 0) && (cyc - last_rise != 4)) mon_err++;
      last_rise = cyc;
      rise_cnt++;
    end
    if (!sck && sck_d && !csb && (rise_cnt >= 24)) begin
      k = rise_cnt - 24;
      if ((k < 8 * len_exp) && (k < 32)) miso = mb[k / 8][7 - (k % 8)];
      else miso = 1'b0;
    end
    if (hif.busy && !busy_d) busy_rise = cyc;
    if (hif.busy) nbusy++;
    if (!csb) ncsb++;
    if (hif.done) begin
      ndone++;
      done_cyc = cyc;
    end
    if (hif.rd_valid) begin
      val_data[nval % 16] = hif.rd_data;
      val_cyc[nval % 16]  = cyc;
      nval++;
    end
    sck_d  = sck;
    csb_d  = csb;
    mosi_d = mosi;
    busy_d = hif.busy;
    rst_d  = reset_n;
  end

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  len;
    logic [23:0] bytes;    // miso bytes, first byte in [23:16]
    logic [23:0] exp_cmd;  // expected 24 bits on mosi
    int          exp_lat;  // cycles from first busy cycle to done cycle
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_miso(input logic [23:0] bytes, input logic [7:0] l);
    mb[0]   = bytes[23:16];
    mb[1]   = bytes[15:8];
    mb[2]   = bytes[7:0];
    mb[3]   = 8'h00;
    len_exp = int'(l);
  endtask

  task automatic start_pulse(input logic [15:0] a, input logic [7:0] l);
    tick();
    hif.start = 1'b1;
    hif.addr  = a;
    hif.len   = l;
    tick();
    hif.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int base;
    int n;
    base = ndone;
    n = 0;
    while ((ndone == base) && (n < budget)) begin
      tick();
      n++;
    end
    if (ndone == base) check("done within budget", 0, 1);
  endtask

  task automatic check_txn(input logic [23:0] ecmd, input logic [7:0] l,
                           input logic [23:0] bytes, input int elat, input int vb);
    check("cmd+addr on mosi", mosi_cap, ecmd);
    check("rd_valid count", nval - vb, l);
    for (int i = 0; (i < int'(l)) && (i < 3) && (i < nval - vb); i++) begin
      logic [7:0] eb;
      eb = bytes[23 - 8 * i -: 8];
      check("rd_data", val_data[(vb + i) % 16], eb);
      if (i == 0) check("first rd_valid offset", val_cyc[vb % 16] - busy_rise, 128);
      else check("rd_valid spacing", val_cyc[(vb + i) % 16] - val_cyc[(vb + i - 1) % 16], 32);
    end
    check("done latency", done_cyc - busy_rise, elat);
  endtask

  task automatic run_vec(input logic [15:0] a, input logic [7:0] l, input logic [23:0] bytes,
                         input logic [23:0] ecmd, input int elat);
    int vb;
    set_miso(bytes, l);
    vb = nval;
    start_pulse(a, l);
    wait_done(400);
    check_txn(ecmd, l, bytes, elat, vb);
    tick();
    check("busy after done", hif.busy, 0);
    check("csb after done", csb, 1);
  endtask

  initial begin
    int vb, nd, nb, nc;
    hif.start = 1'b0;
    hif.addr  = '0;
    hif.len   = '0;

    vecs[0] = '{16'h1234, 8'd1, 24'hA50000, 24'h031234, 136};
    vecs[1] = '{16'h5AC3, 8'd3, 24'h0180FF, 24'h035AC3, 200};
    vecs[2] = '{16'hFFFF, 8'd2, 24'h3CC300, 24'h03FFFF, 168};
    vecs[3] = '{16'h0000, 8'd1, 24'h810000, 24'h030000, 136};

    // reset state
    repeat (3) tick();
    check("reset csb", csb, 1);
    check("reset sck", sck, 0);
    check("reset mosi", mosi, 0);
    check("reset busy", hif.busy, 0);
    check("reset done", hif.done, 0);
    check("reset rd_valid", hif.rd_valid, 0);
    check("reset rd_data", hif.rd_data, 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // table-driven transactions
    for (int i = 0; i < 4; i++)
      run_vec(vecs[i].addr, vecs[i].len, vecs[i].bytes, vecs[i].exp_cmd, vecs[i].exp_lat);

    // len = 0 is ignored
    nb = nbusy; nc = ncsb; nd = ndone;
    start_pulse(16'h4321, 8'd0);
    repeat (20) tick();
    check("len0 busy cycles", nbusy - nb, 0);
    check("len0 csb low cycles", ncsb - nc, 0);
    check("len0 done count", ndone - nd, 0);

    // start during SHIFT is ignored
    set_miso(24'h960000, 8'd1);
    vb = nval;
    start_pulse(16'h2468, 8'd1);
    repeat (40) tick();
    start_pulse(16'hFFFF, 8'd5);
    wait_done(400);
    check_txn(24'h032468, 8'd1, 24'h960000, 136, vb);

    // reset in the high phase of addr[5] (frame bit 18)
    tick();
    set_miso(24'hC30000, 8'd1);
    vb = nval; nd = ndone;
    start_pulse(16'hBEEF, 8'd1);
    repeat (76) tick();
    check("pre-abort sck high", sck, 1);
    check("pre-abort csb low", csb, 0);
    check("pre-abort mosi = addr[5]", mosi, 1);
    #2 reset_n = 1'b0;
    #1;
    check("abort csb", csb, 1);
    check("abort sck", sck, 0);
    check("abort busy", hif.busy, 0);
    check("abort mosi", mosi, 0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (20) tick();
    check("abort done count", ndone - nd, 0);
    check("abort rd_valid count", nval - vb, 0);
    check("abort rd_data", hif.rd_data, 0);
    check("abort idle csb", csb, 1);
    run_vec(16'h0000, 8'd1, 24'h5E0000, 24'h030000, 136);

    // start coincident with done is ignored; the next cycle's start is taken
    set_miso(24'h770000, 8'd1);
    vb = nval;
    start_pulse(16'h0F0F, 8'd1);
    wait_done(400);
    check_txn(24'h030F0F, 8'd1, 24'h770000, 136, vb);
    hif.start = 1'b1;
    hif.addr  = 16'hAAAA;
    hif.len   = 8'd1;
    tick();
    check("start with done ignored", hif.busy, 0);
    set_miso(24'h3A0000, 8'd1);
    vb = nval;
    hif.addr = 16'h1357;
    tick();
    hif.start = 1'b0;
    check("start after done accepted", hif.busy, 1);
    wait_done(400);
    check_txn(24'h031357, 8'd1, 24'h3A0000, 136, vb);

    repeat (4) tick();
    check("protocol monitor errors", mon_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rm25c256_rd_ctrl.md
RM25C256_RD_CTRL -- requirements
Module: rm25c256_rd_ctrl

Interface
REQ-001 Parameter CLK_SCK_SCAL, default 40, clk cycles per SCK period; SHALL be even and >= 4; half-period H = CLK_SCK_SCAL/2.
REQ-002 Parameter LEN_W, default 8, width of the byte-count input.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle read request; accepted only in IDLE with len != 0.
REQ-006 addr  input  16  EEPROM start byte address, captured on accept.
REQ-007 len  input  LEN_W  number of bytes to read, captured on accept.
REQ-008 busy  output  1  high from the accept cycle until the done cycle inclusive.
REQ-009 done  output  1  one-cycle pulse at transaction end.
REQ-010 csb  output  1  SPI chip select, active-low.
REQ-011 sck  output  1  SPI clock, mode 0 (idle low).
REQ-012 mosi  output  1  SPI serial out, MSB first.
REQ-013 miso  input  1  SPI serial in, sampled on SCK rising edge.
REQ-014 rd_data  output  8  received byte, valid when rd_valid is high.
REQ-015 rd_valid  output  1  one-cycle strobe per received byte.

Function
REQ-016 States: IDLE, SETUP, SHIFT, HOLD, DESEL; only IDLE accepts start.
REQ-017 Accept: in IDLE, start=1 and len!=0 -> capture addr/len, load shift register {8'h03, addr}, go to SETUP, busy=1; start with len=0 -> ignored, no output change.
REQ-018 start while not IDLE SHALL be ignored; captured addr/len unchanged.
REQ-019 SETUP: csb=0, sck=0, mosi=bit 23 of shift register (command MSB) for H cycles, then SHIFT.
REQ-020 SHIFT: each bit occupies CLK_SCK_SCAL cycles: sck=0 for first H cycles, sck=1 for last H cycles.
REQ-021 mosi changes only in the cycle sck goes 1->0 (or on SETUP entry); 24 bits sent: 0x03 then addr[15:8], addr[7:0]; mosi=0 during data bits.
REQ-022 miso SHALL be sampled in the cycle sck goes 0->1, only for data bits (bit counter >= 24); shifted in MSB first.
REQ-023 After the 8th sample of each byte, rd_data SHALL be updated and rd_valid pulsed the next clk cycle; exactly len pulses per transaction.
REQ-024 SHIFT lasts (24 + 8*len)*CLK_SCK_SCAL cycles; bit counter width sufficient for 24 + 8*(2^LEN_W - 1) without wrap.
REQ-025 HOLD: after last bit high phase, sck=0, csb=0, mosi=0 for H cycles, then DESEL.
REQ-026 DESEL: csb=1 for CLK_SCK_SCAL cycles, then done=1 for one cycle, busy=0 and state IDLE in that same cycle's end.
REQ-027 A new start is accepted the cycle after done; a start coincident with done is ignored.
REQ-028 Address is not incremented by the block; the EEPROM auto-increments, wrap from 16'hFFFF is the device's behaviour.
REQ-029 Outside a transaction: csb=1, sck=0, mosi=0, rd_valid=0, done=0.

Reset
REQ-030 reset_n=0 SHALL immediately (asynchronously) force IDLE, csb=1, sck=0, mosi=0, busy=0, done=0, rd_valid=0, rd_data=0, counters and shift registers 0.
REQ-031 Reset mid-transaction SHALL abort it with no done and no further rd_valid; after release first start is accepted normally.
REQ-032 Reset deassertion SHALL take effect on the next posedge clk; no output glitch on release.

Verification (CLK_SCK_SCAL=4, H=2)
REQ-033 start, addr=16'h1234, len=1, miso model returns 8'hA5 -> mosi bits 0x03,0x12,0x34; rd_data=8'hA5 with one rd_valid; done after 2+32*4+2+4 cycles from accept.
REQ-034 len=3, miso returns 8'h01,8'h80,8'hFF -> three rd_valid pulses in order with those values, each 32 cycles apart.
REQ-035 start with len=0 in IDLE -> busy stays 0, csb stays 1, no done.
REQ-036 start pulsed during SHIFT with addr=16'hFFFF -> ignored; transmitted address remains first-captured value.
REQ-037 reset_n low during address bit 5 -> csb=1, sck=0, busy=0 same cycle; no done/rd_valid; subsequent read of addr=16'h0000 len=1 completes correctly.
REQ-038 Checker: sck period exactly 4 cycles while csb=0; mosi never changes while sck=1; csb never toggles while sck=1.
